// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/redirect sequencer for the 5-stage pipeline
module pipe_ctrl #(
  parameter int PC_WIDTH       = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int MC_LAT         = 4,
  parameter int CNT_W          = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_en,
  input  logic [GPR_ADDR_WIDTH-1:0] dec_rs1_addr,
  input  logic [GPR_ADDR_WIDTH-1:0] dec_rs2_addr,
  input  logic                      dec_rs1_used,
  input  logic                      dec_rs2_used,
  input  logic                      load_in_id_ex,
  input  logic [GPR_ADDR_WIDTH-1:0] ex_dst_addr,
  input  logic                      branch_taken,
  input  logic [PC_WIDTH-1:0]       branch_target,
  input  logic                      mc_start,
  input  logic                      exp_valid,
  input  logic [PC_WIDTH-1:0]       exp_pc,
  input  logic [3:0]                exp_cause,
  input  logic                      mret_en,
  input  logic [PC_WIDTH-1:0]       mtvec,
  input  logic [PC_WIDTH-1:0]       mepc_in,
  output logic                      if_stall,
  output logic                      id_stall,
  output logic                      if_flush,
  output logic                      id_flush,
  output logic                      ex_flush,
  output logic                      pc_redirect,
  output logic [PC_WIDTH-1:0]       redirect_pc,
  output logic                      trap_we,
  output logic [PC_WIDTH-1:0]       trap_mepc,
  output logic [3:0]                trap_mcause,
  output logic                      busy
);

  typedef enum logic [1:0] {RUN, MC_WAIT, TRAP_JUMP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hazard;

  assign hazard = load_in_id_ex && (ex_dst_addr != '0) &&
                  ((dec_rs1_used && (dec_rs1_addr == ex_dst_addr)) ||
                   (dec_rs2_used && (dec_rs2_addr == ex_dst_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else if (cpu_en) begin
      case (state)
        RUN: begin
          if (exp_valid) begin
            state <= TRAP_JUMP;
          end else if (!mret_en && !branch_taken && mc_start) begin
            state <= MC_WAIT;
            cnt   <= CNT_W'(MC_LAT - 1);
          end
        end
        MC_WAIT: begin
          if (exp_valid) begin
            state <= TRAP_JUMP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= RUN;
          end
        end
        TRAP_JUMP: state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

  // Outputs are decoded from state and inputs; reset and cpu_en=0 silence everything.
  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    trap_we     = 1'b0;
    trap_mepc   = '0;
    trap_mcause = '0;
    busy        = 1'b0;
    if (rst_n && cpu_en) begin
      busy = (state != RUN);
      if (state == TRAP_JUMP) begin
        pc_redirect = 1'b1;
        redirect_pc = mtvec;
        if_flush    = 1'b1;
        id_flush    = 1'b1;
      end else if (exp_valid) begin
        if_flush    = 1'b1;
        id_flush    = 1'b1;
        ex_flush    = 1'b1;
        trap_we     = 1'b1;
        trap_mepc   = exp_pc;
        trap_mcause = exp_cause;
      end else if (state == MC_WAIT) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_flush = 1'b1;
      end else if (mret_en || branch_taken) begin
        pc_redirect = 1'b1;
        redirect_pc = mret_en ? mepc_in : branch_target;
        if_flush    = 1'b1;
        id_flush    = 1'b1;
      end else if (mc_start) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_flush = 1'b1;
      end else if (hazard) begin
        if_stall = 1'b1;
        id_flush = 1'b1;
      end
    end
  end

endmodule
